program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Fetch-stage program counter of the single-cycle RISC-V core; holds the address of the instruction currently being fetched.
- Each clock edge selects the next PC: sequential (pc+4), conditional-branch target (pc+imm) or register-indirect jump target ((src1+imm) with bit 0 cleared, JALR semantics).
- Select strobes come from decode/branch-compare logic; operands come from the register file and immediate generator.

Parameters:
- XLEN, 32, datapath width of pc, src1_value, imm_value.
- RESET_ADDR, 32'h0000_0000, value loaded into pc while reset is asserted.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- src1_value  input  XLEN  rs1 register value, base for jump target.
- imm_value  input  XLEN  sign-extended immediate, already in bytes.
- is_branch  input  1  taken conditional branch this cycle.
- is_jump  input  1  register-indirect jump (JALR) this cycle.
- pc  output  XLEN  current program counter (registered).

Behaviour:
- Reset: reset=0 forces pc=RESET_ADDR immediately, independent of clk. pc holds RESET_ADDR while reset stays 0.
- Release: first rising edge with reset=1 applies the next-PC rule to RESET_ADDR.
- Next-PC rule, evaluated combinationally and registered on each rising clk edge while reset=1:
  - is_jump=1: pc <= (src1_value + imm_value) & ~1.
  - else is_branch=1: pc <= pc + imm_value.
  - else: pc <= pc + PC_STEP.
- Priority: is_jump over is_branch when both are 1.
- Arithmetic: modulo 2^XLEN; carry/overflow discarded; wrap-around allowed (e.g. 0xFFFF_FFFC + 4 = 0x0000_0000).
- imm_value is treated as two's complement, so negative offsets move pc backwards.
- Branch target: no alignment masking; bit 0 is cleared for jump targets only.
- Latency: a strobe sampled at edge N takes effect in pc immediately after edge N. Strobes are level-sampled, one redirect per edge; holding a strobe high repeats the redirect every cycle.
- X/undriven strobes are not supported; drivers must keep is_branch/is_jump at 0 when idle.
- pc is a pure register output: no combinational path from inputs to pc.
- Reset asserted mid-operation: pc returns to RESET_ADDR asynchronously; any pending strobes are ignored until reset=1.

Test Plan:
- Reset: drive reset=0 between clock edges -> pc=0x0000_0000 at once and stays there across edges; release -> pc reads 4, 8, 12 on the following edges.
- Sequential wrap: bench forces pc to 0xFFFF_FFF8 via a jump (src1=0xFFFF_FFF8, imm=0) -> subsequent edges give 0xFFFF_FFFC, then 0x0000_0000.
- Branch: pc=0x10, imm=0x1, is_branch=1 for one edge -> pc=0x11; strobe dropped -> next edge pc=0x15. Repeat with imm=0xFFFF_FFF0 from pc=0x20 -> pc=0x10.
- Jump: src1=0x12, imm=0x1, is_jump=1 -> pc=0x12 (bit 0 cleared). Hold is_jump for 3 edges -> pc stays 0x12. Drop it -> pc=0x16.
- Priority: is_branch=1 and is_jump=1 together with pc=0x40, src1=0x100, imm=0x8 -> pc=0x108.
- Async reset mid-run: assert reset=0 while is_jump=1 and pc=0x108 -> pc=0x0 before the next edge; release -> pc follows the jump rule on the first edge.

Source files
------------

// File: rtl/program_counter.sv
// Fetch-stage program counter: holds the address of the instruction being
// fetched and selects sequential, branch or register-indirect jump next-PC.
module program_counter #(
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_ADDR = '0,
  parameter int unsigned      PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] imm_value,
  input  logic            is_branch,
  input  logic            is_jump,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_sum;
  logic [XLEN-1:0] jump_target;

  // Candidate targets; all sums wrap modulo 2^XLEN with carry discarded.
  always_comb begin
    seq_target    = pc_q + XLEN'(PC_STEP);
    branch_target = pc_q + imm_value;
    jump_sum      = src1_value + imm_value;
    jump_target   = {jump_sum[XLEN-1:1], 1'b0};
  end

  // Next-PC select: jump beats branch, otherwise fall through sequentially.
  always_comb begin
    pc_d = seq_target;
    if (is_jump) begin
      pc_d = jump_target;
    end else if (is_branch) begin
      pc_d = branch_target;
    end
  end

  // PC register; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed, table-driven bench for program_counter.
module tb_program_counter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic [XLEN-1:0] src1_value;
  logic [XLEN-1:0] imm_value;
  logic            is_branch;
  logic            is_jump;
  logic [XLEN-1:0] pc;

  int checks;
  int errors;

  typedef struct {
    string           name;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] imm;
    logic            br;
    logic            jp;
    logic [XLEN-1:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  program_counter #(
    .XLEN       (32),
    .RESET_ADDR (32'h0000_0000),
    .PC_STEP    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src1_value (src1_value),
    .imm_value  (imm_value),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, pc=%h", pc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: pc=%h expected %h", name, act, exp);
    end
  endtask

  // Wait for the next rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] s, input logic [XLEN-1:0] i,
                       input logic br, input logic jp);
    src1_value = s;
    imm_value  = i;
    is_branch  = br;
    is_jump    = jp;
  endtask

  task automatic add(input string n, input logic [XLEN-1:0] s,
                     input logic [XLEN-1:0] i, input logic br, input logic jp,
                     input logic [XLEN-1:0] e);
    vec_t v;
    v.name = n; v.src1 = s; v.imm = i; v.br = br; v.jp = jp; v.exp_pc = e;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Vectors start from pc = 0 right after reset release.
    add("seq_1",        32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0004);
    add("seq_2",        32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0008);
    add("seq_3",        32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_000C);
    add("jump_near_top",32'hFFFF_FFF8, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFF8);
    add("seq_top",      32'h0,         32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC);
    add("seq_wrap",     32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0000);
    add("jump_0x10",    32'h10,        32'h0,         1'b0, 1'b1, 32'h0000_0010);
    add("branch_odd",   32'h0,         32'h1,         1'b1, 1'b0, 32'h0000_0011);
    add("seq_after_br", 32'h0,         32'h1,         1'b0, 1'b0, 32'h0000_0015);
    add("jump_0x20",    32'h20,        32'h0,         1'b0, 1'b1, 32'h0000_0020);
    add("branch_neg",   32'h0,         32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0000_0010);
    add("jump_clr_b0",  32'h12,        32'h1,         1'b0, 1'b1, 32'h0000_0012);
    add("jump_hold_2",  32'h12,        32'h1,         1'b0, 1'b1, 32'h0000_0012);
    add("jump_hold_3",  32'h12,        32'h1,         1'b0, 1'b1, 32'h0000_0012);
    add("seq_after_jp", 32'h12,        32'h1,         1'b0, 1'b0, 32'h0000_0016);
    add("jump_odd_sum", 32'h101,       32'h2,         1'b0, 1'b1, 32'h0000_0102);
    add("branch_nomask",32'h0,         32'h3,         1'b1, 1'b0, 32'h0000_0105);
    add("branch_hold_1",32'h0,         32'h10,        1'b1, 1'b0, 32'h0000_0115);
    add("branch_hold_2",32'h0,         32'h10,        1'b1, 1'b0, 32'h0000_0125);
    add("jump_0x40",    32'h40,        32'h0,         1'b0, 1'b1, 32'h0000_0040);
    add("priority",     32'h100,       32'h8,         1'b1, 1'b1, 32'h0000_0108);

    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);

    // Let pc move away from the reset value before asserting reset.
    step();
    step();
    step();
    #3;
    reset = 1'b0;
    #1;
    check("reset_async", pc, 32'h0000_0000);
    step();
    check("reset_hold_1", pc, 32'h0000_0000);
    step();
    check("reset_hold_2", pc, 32'h0000_0000);
    reset = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].src1, vecs[k].imm, vecs[k].br, vecs[k].jp);
      step();
      check(vecs[k].name, pc, vecs[k].exp_pc);
    end

    // pc must not react to input changes between edges.
    drive(32'h0000_0F00, 32'h0000_0040, 1'b1, 1'b1);
    #2;
    check("no_comb_path", pc, 32'h0000_0108);

    // Async reset while a jump is pending, then release into a jump.
    drive(32'h100, 32'h8, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("reset_mid_run", pc, 32'h0000_0000);
    step();
    check("reset_ignores_jump", pc, 32'h0000_0000);
    drive(32'h200, 32'h5, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    check("release_jump", pc, 32'h0000_0204);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("release_seq", pc, 32'h0000_0208);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
